spi_rf_bridge: RTL and testbench

SPI_RF_BRIDGE -- requirements
Module: spi_rf_bridge

---
 rtl/spi_rf_bridge_if.sv | 43 ++++
 rtl/spi_rf_bridge.sv | 193 +++++++++++++++++++
 tb/tb_spi_rf_bridge.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_rf_bridge_if.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------+
// | spi_rf_bridge_if : SPI pins and regfile port of spi_rf_bridge      |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`ifndef RF_AWIDTH
`define RF_AWIDTH 4
`endif
`ifndef RF_WIDTH
`define RF_WIDTH 32
`endif
`ifndef RF_MASK
`define RF_MASK 4
`endif

interface spi_rf_bridge_if #(
  parameter int AWIDTH = `RF_AWIDTH,
  parameter int WIDTH  = `RF_WIDTH,
  parameter int MASK   = `RF_MASK
);
  logic              sclk;
  logic              cs_n;
  logic              mosi;
  logic              miso;
  logic [AWIDTH-1:0] addr;
  logic              we;
  logic [WIDTH-1:0]  wdata;
  logic [MASK-1:0]   wmask;
  logic [WIDTH-1:0]  rdata;

  // slave: the bridge; master: SPI host plus regfile
  modport slave (
    input  sclk, cs_n, mosi, rdata,
    output miso, addr, we, wdata, wmask
  );
  modport master (
    output sclk, cs_n, mosi, rdata,
    input  miso, addr, we, wdata, wmask
  );
endinterface

`default_nettype wire

// File: rtl/spi_rf_bridge.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------+
// | spi_rf_bridge : SPI mode-0 target translating frames into regfile  |
// |                 word reads and byte-masked writes                  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`ifndef RF_AWIDTH
`define RF_AWIDTH 4
`endif
`ifndef RF_WIDTH
`define RF_WIDTH 32
`endif
`ifndef RF_MASK
`define RF_MASK 4
`endif

module spi_rf_bridge #(
  parameter int AWIDTH = `RF_AWIDTH,
  parameter int WIDTH  = `RF_WIDTH,
  parameter int MASK   = `RF_MASK
) (
  input  wire logic        clk,
  input  wire logic        rst_n,
  spi_rf_bridge_if.slave   bus
);

  localparam int c_CNT_W = $clog2(WIDTH);
  localparam logic [c_CNT_W-1:0] c_CMD_LAST  = c_CNT_W'(7);
  localparam logic [c_CNT_W-1:0] c_ADDR_LAST = c_CNT_W'(15);
  localparam logic [c_CNT_W-1:0] c_WORD_LAST = c_CNT_W'(WIDTH-1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CMD  = 2'd1,
    S_ADDR = 2'd2,
    S_DATA = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;

  logic [1:0]         r_sclk_s;
  logic               r_sclk_d;
  logic [1:0]         r_cs_s;
  logic               r_cs_d;
  logic [1:0]         r_mosi_s;
  logic [1:0]         r_flush;

  logic [c_CNT_W-1:0] r_bit_cnt;
  logic [WIDTH-1:0]   r_shift;
  logic               r_wr;
  logic [MASK-1:0]    r_mask;
  logic [AWIDTH-1:0]  r_addr;
  logic               r_we;
  logic [WIDTH-1:0]   r_wdata;
  logic [MASK-1:0]    r_wmask;
  logic               r_word_done;
  logic               r_load;

  logic               w_sclk_rise;
  logic               w_sclk_fall;
  logic               w_cs_high;
  logic               w_cs_fall;
  logic [WIDTH-1:0]   w_shift_in;

  // Synchronizers and edge detectors
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sclk_s <= 2'b00;
      r_sclk_d <= 1'b0;
      r_cs_s   <= 2'b11;
      r_cs_d   <= 1'b0;
      r_mosi_s <= 2'b00;
      r_flush  <= 2'd0;
    end else begin
      r_sclk_s <= {r_sclk_s[0], bus.sclk};
      r_sclk_d <= r_sclk_s[1];
      r_cs_s   <= {r_cs_s[0], bus.cs_n};
      r_mosi_s <= {r_mosi_s[0], bus.mosi};
      if (r_flush != 2'd3) begin
        r_flush <= r_flush + 2'd1;
      end
      // Until the synchronizer holds real pin values, a held-low cs_n
      // must not look like a fresh falling edge.
      r_cs_d <= (r_flush == 2'd3) ? r_cs_s[1] : 1'b0;
    end
  end

  assign w_sclk_rise = r_sclk_s[1] & ~r_sclk_d;
  assign w_sclk_fall = ~r_sclk_s[1] & r_sclk_d;
  assign w_cs_high   = r_cs_s[1];
  assign w_cs_fall   = r_cs_d & ~r_cs_s[1];
  assign w_shift_in  = {r_shift[WIDTH-2:0], r_mosi_s[1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_cs_high) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: if (w_cs_fall) w_state_nxt = S_CMD;
        S_CMD:  if (w_sclk_rise && r_bit_cnt == c_CMD_LAST) w_state_nxt = S_ADDR;
        S_ADDR: if (w_sclk_rise && r_bit_cnt == c_ADDR_LAST) w_state_nxt = S_DATA;
        default: w_state_nxt = r_state;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_wr        <= 1'b0;
      r_mask      <= '0;
      r_addr      <= '0;
      r_we        <= 1'b0;
      r_wdata     <= '0;
      r_wmask     <= '0;
      r_word_done <= 1'b0;
      r_load      <= 1'b0;
    end else begin
      r_we        <= 1'b0;
      r_word_done <= 1'b0;
      r_load      <= 1'b0;

      if (r_state == S_IDLE || w_cs_high) begin
        r_bit_cnt <= '0;
      end else if (w_sclk_rise) begin
        if ((r_state == S_ADDR && r_bit_cnt == c_ADDR_LAST) ||
            (r_state == S_DATA && r_bit_cnt == c_WORD_LAST)) begin
          r_bit_cnt <= '0;
        end else begin
          r_bit_cnt <= r_bit_cnt + c_CNT_W'(1);
        end

        // Read data moves out on falling edges only
        if (!(r_state == S_DATA && !r_wr)) begin
          r_shift <= w_shift_in;
        end

        if (r_state == S_CMD && r_bit_cnt == c_CMD_LAST) begin
          r_wr   <= w_shift_in[7];
          r_mask <= w_shift_in[3 +: MASK];
        end

        if (r_state == S_ADDR && r_bit_cnt == c_ADDR_LAST) begin
          r_addr <= w_shift_in[AWIDTH-1:0];
          r_load <= ~r_wr;
        end

        if (r_state == S_DATA && r_bit_cnt == c_WORD_LAST) begin
          r_word_done <= 1'b1;
          if (r_wr) begin
            r_we    <= 1'b1;
            r_wdata <= w_shift_in;
            r_wmask <= r_mask;
          end
        end
      end else if (w_sclk_fall && r_state == S_DATA && !r_wr &&
                   r_bit_cnt != '0) begin
        // The fall right after a word boundary keeps the freshly loaded MSB
        r_shift <= {r_shift[WIDTH-2:0], 1'b0};
      end

      if (r_word_done) begin
        r_addr <= r_addr + AWIDTH'(1);
        r_load <= ~r_wr;
      end

      if (r_load) begin
        r_shift <= bus.rdata;
      end
    end
  end

  assign bus.addr  = r_addr;
  assign bus.we    = r_we;
  assign bus.wdata = r_wdata;
  assign bus.wmask = r_wmask;
  assign bus.miso  = (r_state == S_DATA && !r_wr) ? r_shift[WIDTH-1] : 1'b0;

endmodule

`default_nettype wire

// File: tb/tb_spi_rf_bridge.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------+
// | tb_spi_rf_bridge : SPI host + regfile with scoreboard for bridge   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_spi_rf_bridge;

  localparam int AW   = 4;
  localparam int HALF = 8;     // clk cycles per sclk half period
  localparam int NW   = 1 << AW;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [31:0]   d;
    logic [3:0]    m;
  } wr_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic load_mem = 1'b1;
  always #5 clk = ~clk;

  spi_rf_bridge_if #(.AWIDTH(AW), .WIDTH(32), .MASK(4)) bus ();

  spi_rf_bridge #(.AWIDTH(AW), .WIDTH(32), .MASK(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [31:0] init_val [NW];
  logic [31:0] mem      [NW];
  logic [31:0] ref_mem  [NW];
  logic [31:0] tx       [4];

  wr_t         exp_wr [$];
  logic [31:0] exp_rd [$];
  logic [31:0] obs_rd [$];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Regfile: combinational read, byte-masked write (mask bit i -> byte i)
  assign bus.rdata = mem[bus.addr];
  always @(posedge clk) begin
    if (load_mem) begin
      for (int i = 0; i < NW; i++) mem[i] <= init_val[i];
    end else if (bus.we) begin
      for (int b = 0; b < 4; b++)
        if (bus.wmask[b]) mem[bus.addr][8*b +: 8] <= bus.wdata[8*b +: 8];
    end
  end

  // Monitor: pops expectations as the DUT produces writes and read words
  always @(negedge clk) begin
    wr_t e;
    logic [31:0] o, x;
    if (rst_n && bus.we) begin
      if (exp_wr.size() == 0) begin
        check("unexpected_we", 32'd1, 32'd0);
      end else begin
        e = exp_wr.pop_front();
        check("we_addr",  32'(bus.addr),  32'(e.a));
        check("we_wdata", bus.wdata,       e.d);
        check("we_wmask", 32'(bus.wmask), 32'(e.m));
      end
    end
    if (obs_rd.size() > 0) begin
      o = obs_rd.pop_front();
      if (exp_rd.size() == 0) begin
        check("unexpected_rd_word", o, 32'hxxxx_xxxx);
      end else begin
        x = exp_rd.pop_front();
        check("miso_word", o, x);
      end
    end
  end

  task automatic xfer_bit(input logic b, output logic m);
    bus.mosi = b;
    repeat (HALF) @(posedge clk);
    @(negedge clk);
    m = bus.miso;
    bus.sclk = 1'b1;
    repeat (HALF) @(posedge clk);
    bus.sclk = 1'b0;
  endtask

  task automatic end_frame();
    repeat (HALF) @(posedge clk);
    bus.cs_n = 1'b1;
    repeat (6 * HALF) @(posedge clk);
    check("wr_pending", 32'(exp_wr.size()), 32'd0);
    check("rd_pending", 32'(exp_rd.size()), 32'd0);
  endtask

  // stop_after < 0 sends every data bit; otherwise cs stays low after
  // that many data bits (caller decides when to raise it)
  task automatic frame(input logic [7:0] cmd, input logic [7:0] a, input int nw,
                       input int stop_after, input bit keep_cs);
    logic          m;
    logic [31:0]   rw;
    logic [AW-1:0] wa;
    wr_t           t;
    int            sent;
    bit            wr;
    wr   = cmd[7];
    sent = 0;
    for (int w = 0; w < nw; w++) begin
      if (stop_after < 0 || (w + 1) * 32 <= stop_after) begin
        wa = a[AW-1:0] + AW'(w);
        if (wr) begin
          t.a = wa; t.d = tx[w]; t.m = cmd[6:3];
          exp_wr.push_back(t);
          for (int b = 0; b < 4; b++)
            if (cmd[3+b]) ref_mem[wa][8*b +: 8] = tx[w][8*b +: 8];
        end else begin
          exp_rd.push_back(ref_mem[wa]);
        end
      end
    end
    bus.cs_n = 1'b0;
    repeat (HALF) @(posedge clk);
    for (int i = 7; i >= 0; i--) begin
      xfer_bit(cmd[i], m);
      check("miso_cmd_phase", 32'(m), 32'd0);
    end
    for (int i = 7; i >= 0; i--) begin
      xfer_bit(a[i], m);
      check("miso_addr_phase", 32'(m), 32'd0);
    end
    for (int w = 0; w < nw; w++) begin
      rw = '0;
      for (int i = 31; i >= 0; i--) begin
        if (stop_after >= 0 && sent >= stop_after) break;
        xfer_bit(tx[w][i], m);
        rw = {rw[30:0], m};
        sent++;
        if (wr) check("miso_write_frame", 32'(m), 32'd0);
      end
      if (stop_after >= 0 && sent >= stop_after && (sent % 32) != 0) break;
      if (!wr) obs_rd.push_back(rw);
      if (stop_after >= 0 && sent >= stop_after) break;
    end
    if (!keep_cs) end_frame();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_addr"},  32'(bus.addr),  32'd0);
    check({tag, "_we"},    32'(bus.we),    32'd0);
    check({tag, "_wdata"}, bus.wdata,      32'd0);
    check({tag, "_wmask"}, 32'(bus.wmask), 32'd0);
    check({tag, "_miso"},  32'(bus.miso),  32'd0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic m;
    bus.sclk = 1'b0;
    bus.cs_n = 1'b1;
    bus.mosi = 1'b0;
    for (int i = 0; i < NW; i++) begin
      init_val[i] = $urandom;
      ref_mem[i]  = init_val[i];
    end
    init_val[0] = 32'h0000_00A5;
    ref_mem[0]  = 32'h0000_00A5;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    load_mem = 1'b0;
    rst_n    = 1'b1;
    repeat (10) @(posedge clk);

    // Single write
    tx[0] = 32'hDEAD_BEEF;
    frame(8'hF8, 8'h03, 1, -1, 1'b0);
    check("addr_after_write", 32'(bus.addr), 32'd4);

    // Single read of word 0
    frame(8'h00, 8'h00, 1, -1, 1'b0);
    check("addr_after_read", 32'(bus.addr), 32'd1);

    // Burst write across the address wrap, mask 0011
    tx[0] = 32'h1122_3344; tx[1] = 32'h5566_7788;
    frame(8'h98, 8'(NW - 1), 2, -1, 1'b0);
    check("addr_after_wrap", 32'(bus.addr), 32'd1);

    // Mask 0000 still pulses we
    tx[0] = 32'hCAFE_F00D;
    frame(8'h80, 8'h06, 1, -1, 1'b0);

    // Abort after 20 data bits, then a normal frame
    tx[0] = 32'h0BAD_0BAD;
    frame(8'hF8, 8'h09, 1, 20, 1'b0);
    check("addr_after_abort", 32'(bus.addr), 32'd9);
    tx[0] = 32'h1234_5678;
    frame(8'hF8, 8'h09, 1, -1, 1'b0);

    // Reset during DATA phase of a write
    tx[0] = 32'hFFFF_FFFF;
    frame(8'hF8, 8'h07, 1, 20, 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("midreset");
    rst_n = 1'b1;
    for (int i = 0; i < 44; i++) begin
      xfer_bit(1'($urandom), m);
      check("miso_after_reset", 32'(m), 32'd0);
    end
    end_frame();
    check("addr_held_after_reset", 32'(bus.addr), 32'd0);
    tx[0] = 32'h0F0F_A5A5;
    frame(8'hF8, 8'h07, 1, -1, 1'b0);

    // Burst read of three words from 5
    frame(8'h00, 8'h05, 3, -1, 1'b0);
    check("addr_after_burst_read", 32'(bus.addr), 32'd8);

    // Randomized frames
    for (int k = 0; k < 12; k++) begin
      for (int w = 0; w < 4; w++) tx[w] = $urandom;
      frame(8'($urandom), 8'($urandom), int'($urandom_range(1, 3)), -1, 1'b0);
    end

    repeat (10) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
